// File: rtl/hamming_21_16_encoder_pipe.sv
// Streaming Hamming(21,16) encoder with a two-stage valid/ready pipeline.
// S1 holds the data word and its five parity bits. S2 holds the assembled
// codeword, optionally with one bit flipped. A wrapping counter tracks
// completed output handshakes.
module hamming_21_16_encoder_pipe #(
    parameter bit INJECT_EN = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             inj_arm,
    input  logic [4:0]       inj_pos,
    output logic             inj_pending,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [20:0]      out_code,
    output logic             out_injected,
    output logic [CNT_W-1:0] word_count
);

    // Parity coverage masks over d[15:0] for parity positions 1,2,4,8,16
    localparam logic [15:0] MASK_P1  = 16'hAD5B;
    localparam logic [15:0] MASK_P2  = 16'h366D;
    localparam logic [15:0] MASK_P4  = 16'hC78E;
    localparam logic [15:0] MASK_P8  = 16'h07F0;
    localparam logic [15:0] MASK_P16 = 16'hF800;

    // Codeword bit index of data bit d[gi]
    localparam int DATA_IDX [16] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14, 16, 17, 18, 19, 20};

    // Codeword bit index of parity bit p[gi] (p1,p2,p4,p8,p16)
    localparam int PAR_IDX [5] = '{0, 1, 3, 7, 15};

    logic        s1_valid_q;
    logic [15:0] s1_data_q;
    logic [4:0]  s1_par_q;
    logic [4:0]  par_d;

    logic        s2_valid_q;
    logic [20:0] s2_code_q;
    logic        s2_inj_q;

    logic        inj_pending_q;
    logic [4:0]  inj_pos_q;

    logic [CNT_W-1:0] count_q;

    logic        s2_load;
    logic        accept;
    logic        out_fire;
    logic        arm_ok;
    logic [20:0] code_clean;
    logic [20:0] flip_mask;

    assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_load;
    assign accept   = in_valid && in_ready;
    assign out_fire = s2_valid_q && out_ready;
    assign arm_ok   = inj_arm && (inj_pos <= 5'd20);

    assign par_d = {^(in_data & MASK_P16), ^(in_data & MASK_P8), ^(in_data & MASK_P4),
                    ^(in_data & MASK_P2),  ^(in_data & MASK_P1)};

    // Scatter S1 data and parity into their codeword positions
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_data
            assign code_clean[DATA_IDX[gi]] = s1_data_q[gi];
        end
        for (genvar gi = 0; gi < 5; gi++) begin : g_par
            assign code_clean[PAR_IDX[gi]] = s1_par_q[gi];
        end
    endgenerate

    // A pending injection lands on whichever word moves into S2 next
    assign flip_mask = inj_pending_q ? (21'd1 << inj_pos_q) : 21'd0;

    // S1: capture the accepted word with its parity; empty when S2 drains it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_par_q   <= '0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_data_q  <= in_data;
            s1_par_q   <= par_d;
        end else if (s2_load) begin
            s1_valid_q <= 1'b0;
        end
    end

    // S2: assemble and optionally corrupt the codeword; hold it while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_code_q  <= '0;
            s2_inj_q   <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= 1'b1;
            s2_code_q  <= code_clean ^ flip_mask;
            s2_inj_q   <= inj_pending_q;
        end else if (out_fire) begin
            s2_valid_q <= 1'b0;
        end
    end

    generate
        if (INJECT_EN) begin : g_inj
            // Injection arm: a new arm wins over consumption, so an arm on the
            // consuming cycle stays pending for the following word
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    inj_pending_q <= 1'b0;
                    inj_pos_q     <= '0;
                end else if (arm_ok) begin
                    inj_pending_q <= 1'b1;
                    inj_pos_q     <= inj_pos;
                end else if (s2_load) begin
                    inj_pending_q <= 1'b0;
                end
            end
        end else begin : g_no_inj
            assign inj_pending_q = 1'b0;
            assign inj_pos_q     = 5'd0;
        end
    endgenerate

    // Output handshake counter, wraps naturally at its width
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (out_fire) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign inj_pending  = inj_pending_q;
    assign out_valid    = s2_valid_q;
    assign out_code     = s2_code_q;
    assign out_injected = s2_inj_q;
    assign word_count   = count_q;

endmodule
